jt053246_objdma: RTL and testbench

JT053246_OBJDMA -- requirements
Module: jt053246_objdma

---
 rtl/jt053246_objdma_pkg.sv | 30 +++
 rtl/jtframe_dual_ram16.sv | 26 ++
 rtl/jt053246_objdma.sv | 157 +++++++++++++++
 tb/tb_jt053246_objdma.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt053246_objdma_pkg.sv
// Shared constants for the 053246/053244 object DMA: register indices,
// cfg bit positions, FSM encodings and the per-mode transfer length.
package jt053246_objdma_pkg;

  typedef logic [3:0] reg_idx_t;

  localparam reg_idx_t XOFF0 = 4'd0;
  localparam reg_idx_t XOFF1 = 4'd1;
  localparam reg_idx_t YOFF0 = 4'd2;
  localparam reg_idx_t YOFF1 = 4'd3;
  localparam reg_idx_t ROM4  = 4'd4;
  localparam reg_idx_t CFG   = 4'd5;
  localparam reg_idx_t ROM6  = 4'd6;
  localparam reg_idx_t ROM7  = 4'd7;

  localparam int CFG_HFLIP  = 0;
  localparam int CFG_VFLIP  = 1;
  localparam int CFG_ROM8   = 2;
  localparam int CFG_CPUBSY = 3;
  localparam int CFG_DMAEN  = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Step index of the final write: 8 words per object, 128 or 256 objects.
  function automatic logic [11:0] dma_last(input logic short_list);
    return short_list ? 12'd1024 : 12'd2048;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram16.sv
// Simple dual-port 16-bit RAM: port 0 write-only, port 1 registered read-only.
// A read colliding with a write to the same address returns the old word.
module jtframe_dual_ram16 #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr0,
  input  logic [15:0]   data0,
  input  logic          we0,
  input  logic [AW-1:0] addr1,
  output logic [15:0]   q1
);

  logic [15:0] mem_r [0:(1<<AW)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we0) mem_r[addr0] <= data0;
  end

  // Read port, one clock of latency
  always_ff @(posedge clk) begin
    q1 <= mem_r[addr1];
  end

endmodule

// File: rtl/jt053246_objdma.sv
// Object DMA of the Konami 053246/053244: CPU register file plus a DMA that
// copies object RAM from external memory into an even/odd pair of scan banks.
module jt053246_objdma
  import jt053246_objdma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl2_cen,
  input  logic        k44_en,
  input  logic        simson,
  input  logic        cs,
  input  logic        cpu_we,
  input  logic [3:0]  cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        hs,
  input  logic        vs,
  output logic [13:1] dma_addr,
  input  logic [15:0] dma_data,
  output logic        dma_bsy,
  input  logic [9:0]  scan_addr,
  output logic [15:0] scan_even,
  output logic [15:0] scan_odd,
  output logic [7:0]  cfg,
  output logic [9:0]  xoffset,
  output logic [9:0]  yoffset,
  output logic [21:1] rmrd_addr,
  output logic        flicker,
  input  logic [7:0]  st_addr,
  output logic [7:0]  st_dout
);

  logic [7:0]  regs_r [0:15];
  reg_idx_t    wr_idx_s;
  logic        vs_l_r;
  logic        vs_rise_s;
  logic        flicker_r;
  logic        start_s;
  logic [0:0]  state_r;
  logic [11:0] cnt_r;
  logic [11:0] last_s;
  logic [11:1] dma_addr_r;
  logic        wr_step_s;
  logic        dma_wel_s;
  logic        dma_weh_s;
  logic        unused_s;

  assign unused_s = hs;
  assign wr_idx_s = k44_en ? cpu_addr : {1'b0, cpu_addr[2:0]};

  // CPU register file
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_r[i] <= 8'h00;
    end else if (cs && cpu_we) begin
      regs_r[wr_idx_s] <= cpu_dout;
    end
  end

  assign xoffset   = {regs_r[XOFF1][1:0], regs_r[XOFF0]};
  assign yoffset   = {regs_r[YOFF1][1:0], regs_r[YOFF0]};
  assign rmrd_addr = {regs_r[ROM6][4:0], regs_r[ROM7], regs_r[ROM4]};
  assign st_dout   = (st_addr[7:4] == 4'd0) ? regs_r[st_addr[3:0]] : 8'h00;

  // Named cfg bits are routed individually; upper bits pass straight through
  always_comb begin
    cfg             = 8'h00;
    cfg[7:5]        = regs_r[CFG][7:5];
    cfg[CFG_HFLIP]  = regs_r[CFG][CFG_HFLIP];
    cfg[CFG_VFLIP]  = regs_r[CFG][CFG_VFLIP];
    cfg[CFG_ROM8]   = regs_r[CFG][CFG_ROM8];
    cfg[CFG_CPUBSY] = regs_r[CFG][CFG_CPUBSY];
    cfg[CFG_DMAEN]  = regs_r[CFG][CFG_DMAEN];
  end

  // Vertical sync edge detector and debug frame toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_l_r    <= 1'b0;
      flicker_r <= 1'b0;
    end else begin
      vs_l_r <= vs;
      if (vs_rise_s) flicker_r <= ~flicker_r;
    end
  end

  assign vs_rise_s = vs & ~vs_l_r;
  assign flicker   = flicker_r;

  // 053244 starts on any access to register 6/7, 053246 on the frame edge
  always_comb begin
    if (k44_en) begin
      start_s = cs && (cpu_addr[2:1] == 2'b11);
    end else begin
      start_s = vs_rise_s && cfg[CFG_DMAEN];
    end
  end

  assign last_s = dma_last(k44_en | simson);

  // DMA sequencer: step k presents word k and writes the word fetched at k-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 12'd0;
      dma_addr_r <= 11'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            state_r <= ST_RUN;
            cnt_r   <= 12'd0;
          end
        end
        ST_RUN: begin
          if (pxl2_cen) begin
            if (cnt_r == last_s) begin
              state_r <= ST_IDLE;
              cnt_r   <= 12'd0;
            end else begin
              cnt_r      <= cnt_r + 12'd1;
              dma_addr_r <= cnt_r[10:0];
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 12'd0;
        end
      endcase
    end
  end

  assign dma_addr  = {2'b00, dma_addr_r};
  assign dma_bsy   = (state_r == ST_RUN);
  assign wr_step_s = dma_bsy && pxl2_cen && (cnt_r != 12'd0) && !rst;
  assign dma_wel_s = wr_step_s && !dma_addr_r[1];
  assign dma_weh_s = wr_step_s &&  dma_addr_r[1];

  jtframe_dual_ram16 #(.AW(10)) u_even (
    .clk   (clk),
    .addr0 (dma_addr_r[11:2]),
    .data0 (dma_data),
    .we0   (dma_wel_s),
    .addr1 (scan_addr),
    .q1    (scan_even)
  );

  jtframe_dual_ram16 #(.AW(10)) u_odd (
    .clk   (clk),
    .addr0 (dma_addr_r[11:2]),
    .data0 (dma_data),
    .we0   (dma_weh_s),
    .addr1 (scan_addr),
    .q1    (scan_odd)
  );

endmodule

// File: tb/tb_jt053246_objdma.sv
// Directed bench for jt053246_objdma: register decode, DMA runs in both modes,
// abort by reset, and object RAM contents checked against a scoreboard model.
module tb_jt053246_objdma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pxl2_cen = 1'b0;
  logic        k44_en = 1'b0;
  logic        simson = 1'b0;
  logic        cs = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_addr = 4'd0;
  logic [7:0]  cpu_dout = 8'd0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [13:1] dma_addr;
  logic [15:0] dma_data;
  logic        dma_bsy;
  logic [9:0]  scan_addr = 10'd0;
  logic [15:0] scan_even;
  logic [15:0] scan_odd;
  logic [7:0]  cfg;
  logic [9:0]  xoffset;
  logic [9:0]  yoffset;
  logic [21:1] rmrd_addr;
  logic        flicker;
  logic [7:0]  st_addr = 8'd0;
  logic [7:0]  st_dout;

  logic        cen_on = 1'b0;
  logic [15:0] data_xor = 16'h0000;
  logic        exp_flicker = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          busy_steps = 0;
  int          base;
  logic [15:0] exp_even [1024];
  logic [15:0] exp_odd  [1024];
  logic [15:0] q_even [$];
  logic [15:0] q_odd  [$];

  jt053246_objdma dut (
    .clk(clk), .rst(rst), .pxl2_cen(pxl2_cen), .k44_en(k44_en), .simson(simson),
    .cs(cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .hs(hs), .vs(vs), .dma_addr(dma_addr), .dma_data(dma_data), .dma_bsy(dma_bsy),
    .scan_addr(scan_addr), .scan_even(scan_even), .scan_odd(scan_odd),
    .cfg(cfg), .xoffset(xoffset), .yoffset(yoffset), .rmrd_addr(rmrd_addr),
    .flicker(flicker), .st_addr(st_addr), .st_dout(st_dout)
  );

  always #5 clk = ~clk;

  // External RAM: each word holds its own address, optionally scrambled per run
  assign dma_data = {3'b000, dma_addr} ^ data_xor;

  initial forever begin
    @(negedge clk);
    pxl2_cen = cen_on & ~pxl2_cen;
  end

  always @(posedge clk) begin
    if (pxl2_cen && dma_bsy) busy_steps <= busy_steps + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_dout = d;
    @(negedge clk);
    cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic k44_touch(input logic [3:0] a);
    @(negedge clk);
    cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge clk); vs = 1'b0;
    @(negedge clk); vs = 1'b1; exp_flicker = ~exp_flicker;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (dma_bsy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic model_dma(input int words, input logic [15:0] x);
    for (int w = 0; w < words; w++) begin
      if (w % 2 == 0) exp_even[w/2] = 16'(w) ^ x;
      else            exp_odd[w/2]  = 16'(w) ^ x;
    end
  endtask

  task automatic scan_pop(input string tag);
    logic [15:0] e;
    logic [15:0] o;
    e = q_even.pop_front();
    o = q_odd.pop_front();
    chk({tag, "_even"}, 32'(scan_even), 32'(e));
    chk({tag, "_odd"},  32'(scan_odd),  32'(o));
  endtask

  task automatic scan_chk(input string tag, input int a, input logic [15:0] e, input logic [15:0] o);
    @(negedge clk);
    scan_addr = 10'(a);
    q_even.push_back(e);
    q_odd.push_back(o);
    @(negedge clk);
    scan_pop(tag);
  endtask

  task automatic scan_sweep(input string tag);
    for (int a = 0; a <= 1024; a++) begin
      @(negedge clk);
      if (a > 0) scan_pop(tag);
      if (a < 1024) begin
        scan_addr = 10'(a);
        q_even.push_back(exp_even[a]);
        q_odd.push_back(exp_odd[a]);
      end
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_bsy", 32'(dma_bsy), 32'd0);
    chk("rst_cfg", 32'(cfg), 32'd0);
    chk("rst_xoff", 32'(xoffset), 32'd0);
    chk("rst_yoff", 32'(yoffset), 32'd0);
    chk("rst_rmrd", 32'(rmrd_addr), 32'd0);
    chk("rst_flicker", 32'(flicker), 32'd0);
    chk("rst_dma_addr", 32'(dma_addr), 32'd0);
    chk("rst_st_dout", 32'(st_dout), 32'd0);
    rst = 1'b0;
    tick(1);

    // Register decode
    wr(4'd0, 8'h34); wr(4'd1, 8'h02); wr(4'd2, 8'hAB); wr(4'd3, 8'h01);
    chk("xoffset", 32'(xoffset), 32'h234);
    chk("yoffset", 32'(yoffset), 32'h1AB);
    st_addr = 8'd2; #1;
    chk("st_reg2", 32'(st_dout), 32'hAB);
    st_addr = 8'd16; #1;
    chk("st_16", 32'(st_dout), 32'h00);
    wr(4'd6, 8'h1F); wr(4'd7, 8'hFF); wr(4'd4, 8'h80);
    chk("rmrd", 32'(rmrd_addr), 32'h1FFF80);
    wr(4'hC, 8'h81);
    chk("rmrd_bit3_ignored", 32'(rmrd_addr), 32'h1FFF81);
    st_addr = 8'd12; #1;
    chk("st_reg12", 32'(st_dout), 32'h00);

    // 053246 DMA of 256 objects, with a vs edge mid-run that must be ignored
    cen_on = 1'b1;
    wr(4'd5, 8'h10);
    chk("cfg_dmaen", 32'(cfg), 32'h10);
    base = busy_steps;
    vs_pulse();
    chk("bsy_started", 32'(dma_bsy), 32'd1);
    tick(500);
    vs_pulse();
    wait_idle("dma256_timeout", 6000);
    chk("dma256_steps", 32'(busy_steps - base), 32'd2049);
    chk("dma256_flicker", 32'(flicker), 32'(exp_flicker));
    chk("dma256_last_addr", 32'(dma_addr), 32'd2047);
    model_dma(2048, 16'h0000);
    scan_chk("scan5", 5, 16'h000A, 16'h000B);
    scan_sweep("sweep256");

    // DMA disabled: neither vs nor a register-6 access may start a transfer
    data_xor = 16'hC3C3;
    wr(4'd5, 8'h00);
    chk("cfg_off", 32'(cfg), 32'h00);
    base = busy_steps;
    vs_pulse();
    k44_touch(4'd6);
    tick(200);
    chk("nodma_steps", 32'(busy_steps - base), 32'd0);
    chk("nodma_bsy", 32'(dma_bsy), 32'd0);
    chk("nodma_flicker", 32'(flicker), 32'(exp_flicker));
    scan_chk("nodma_scan5", 5, 16'h000A, 16'h000B);
    scan_chk("nodma_scan1000", 1000, 16'h07D0, 16'h07D1);

    // 053244 mode: 128 objects, started by a register-6 access
    k44_en = 1'b1;
    data_xor = 16'hA5A5;
    base = busy_steps;
    k44_touch(4'd6);
    wait_idle("dma128_timeout", 3000);
    chk("dma128_steps", 32'(busy_steps - base), 32'd1025);
    chk("dma128_last_addr", 32'(dma_addr), 32'd1023);
    model_dma(1024, 16'hA5A5);
    scan_chk("k44_scan5", 5, 16'hA5AF, 16'hA5AE);
    scan_chk("k44_scan511", 511, 16'hA65B, 16'hA65A);
    scan_chk("k44_scan512", 512, 16'h0400, 16'h0401);
    scan_chk("k44_obj200", 800, 16'h0640, 16'h0641);
    scan_sweep("sweep128");
    wr(4'hD, 8'h77);
    st_addr = 8'd13; #1;
    chk("k44_st_reg13", 32'(st_dout), 32'h77);
    chk("k44_cfg_kept", 32'(cfg), 32'h00);
    k44_en = 1'b0;

    // Reset around step 100 aborts the transfer
    data_xor = 16'h0F0F;
    wr(4'd5, 8'h10);
    base = busy_steps;
    vs_pulse();
    begin
      int n;
      n = 0;
      while ((busy_steps - base) < 100 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("abort_wait_timeout", 32'(n < 1000), 32'd1);
    end
    rst = 1'b1; vs = 1'b0;
    @(negedge clk);
    chk("abort_bsy", 32'(dma_bsy), 32'd0);
    rst = 1'b0;
    exp_flicker = 1'b0;
    chk("abort_cfg", 32'(cfg), 32'h00);
    chk("abort_xoff", 32'(xoffset), 32'd0);
    chk("abort_rmrd", 32'(rmrd_addr), 32'd0);
    chk("abort_st_reg13", 32'(st_dout), 32'h00);
    chk("abort_flicker", 32'(flicker), 32'(exp_flicker));
    base = busy_steps;
    tick(300);
    chk("abort_no_steps", 32'(busy_steps - base), 32'd0);
    scan_chk("abort_scan10", 10, 16'h0F1B, 16'h0F1A);
    scan_chk("abort_scan100", 100, 16'hA56D, 16'hA56C);
    scan_chk("abort_scan300", 300, 16'hA7FD, 16'hA7FC);

    // Restart after abort covers the whole table from word 0
    data_xor = 16'h1234;
    wr(4'd5, 8'h10);
    base = busy_steps;
    vs_pulse();
    wait_idle("restart_timeout", 6000);
    chk("restart_steps", 32'(busy_steps - base), 32'd2049);
    chk("restart_flicker", 32'(flicker), 32'(exp_flicker));
    model_dma(2048, 16'h1234);
    scan_sweep("sweep_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
